mem_port_arbiter: RTL

//  Shares one single-ported, fixed-latency unified memory between the CPU fetch port (I) and load/store port (D).

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: FSM states, grant owner and counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_e;

  // Wide enough for MEM_LAT-1 and STARVE_MAX, both capped at 15.
  localparam int LAT_W    = 4;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STARVE_W-1:0] cnt;

  assign at_max = (cnt == STARVE_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences fetch (I) and load/store (D) accesses onto one fixed-latency memory port,
// data-first with a bounded number of data grants while a fetch waits.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              hlt_req,
  output logic              halted,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e       state;
  arb_gnt_e         gnt;
  logic             acc_we;
  logic [LAT_W-1:0] lat_cnt;

  logic i_elig;
  logic d_elig;
  logic grant;
  logic pick_d;
  logic at_max;
  logic idle_nxt;
  logic starve_inc;
  logic starve_clr;

  assign i_elig   = i_req & ~hlt_req;
  assign d_elig   = d_req;
  assign grant    = (state == ST_IDLE) & (i_elig | d_elig);
  assign pick_d   = d_elig & ~(i_elig & at_max);
  assign idle_nxt = ((state == ST_IDLE) & ~grant) | (state == ST_RESP);

  // Any grant that is not "data while fetch is pending" restarts the count.
  assign starve_inc = grant & pick_d & i_req;
  assign starve_clr = grant & ~starve_inc;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .at_max(at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= GNT_I;
      acc_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= ~idle_nxt;
      halted    <= hlt_req & idle_nxt;

      case (state)
        ST_IDLE: begin
          if (grant) begin
            state     <= ST_CMD;
            gnt       <= pick_d ? GNT_D : GNT_I;
            acc_we    <= pick_d & d_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : i_addr;
            mem_wdata <= (pick_d & d_we) ? d_wdata : '0;
          end
        end

        ST_CMD: begin
          state   <= ST_WAIT;
          lat_cnt <= LAT_W'(MEM_LAT - 1);
        end

        // Read data is on mem_rdata during the last WAIT cycle.
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ST_RESP;
            if (gnt == GNT_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!acc_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
